// File: rtl/smart_house_pkg.sv
// Shared definitions for the smart-house climate path: sequencer state
// encoding and the temperature word width.
package smart_house_pkg;

    localparam int TEMP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COOL = 2'd1,
        HEAT = 2'd2,
        REST = 2'd3
    } hvac_state_e;

endpackage

// File: rtl/hvac_timer.sv
// Clearable saturating up-counter; done is high once the count has reached MAX.
module hvac_timer #(
    parameter int MAX = 8,
    parameter int CW  = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          done
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != CW'(MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign done = (count == CW'(MAX));

endmodule

// File: rtl/hvac_sequencer.sv
// Cooler/heater sequencer with hysteresis, minimum run time and a rest gap
// between runs. Define HVAC_FAN_OVERRUN_EN to add the fan output with overrun.
module hvac_sequencer
    import smart_house_pkg::*;
#(
    parameter int HYST       = 2,
    parameter int MIN_RUN    = 8,
`ifdef HVAC_FAN_OVERRUN_EN
    parameter int FAN_CYCLES = 6,
`endif
    parameter int MIN_OFF    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] temp_cur,
    input  logic [TEMP_W-1:0] temp_req,
    output logic              cooler,
    output logic              heater,
    output logic              busy,
`ifdef HVAC_FAN_OVERRUN_EN
    output logic              fan,
`endif
    output logic [1:0]        state_o
);

    localparam int TCW       = (MIN_RUN < 1) ? 1 : $clog2(MIN_RUN + 1);
    // Rest is counted on the run timer, so it may last at most MIN_RUN+1 cycles.
    localparam int REST_LAST = (MIN_OFF > 0) ? MIN_OFF - 1 : 0;

    localparam logic signed [TEMP_W:0] HYST_POS = (TEMP_W + 1)'(HYST);
    localparam logic signed [TEMP_W:0] HYST_NEG = -HYST_POS;

    hvac_state_e          state, state_n;
    logic signed [TEMP_W:0] diff;
    logic [TCW-1:0]       tmr_count;
    logic                 run_done;
    logic                 rest_done;
    logic                 tmr_clear;

    // One extra bit of headroom keeps the difference exact for any inputs.
    assign diff = $signed({temp_cur[TEMP_W-1], temp_cur})
                - $signed({temp_req[TEMP_W-1], temp_req});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (enable && sample_valid) begin
                    if (diff > HYST_POS) begin
                        state_n = COOL;
                    end else if (diff < HYST_NEG) begin
                        state_n = HEAT;
                    end
                end
            end
            COOL: begin
                if (!enable || (sample_valid && run_done && diff <= 0)) begin
                    state_n = REST;
                end
            end
            HEAT: begin
                if (!enable || (sample_valid && run_done && diff >= 0)) begin
                    state_n = REST;
                end
            end
            REST: begin
                if (rest_done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Any state change restarts the shared run/rest timer.
    assign tmr_clear = (state_n != state);
    assign rest_done = (tmr_count >= TCW'(REST_LAST));

    hvac_timer #(.MAX(MIN_RUN), .CW(TCW)) u_run_timer (
        .clock (clock),
        .reset (reset),
        .clear (tmr_clear),
        .count (tmr_count),
        .done  (run_done)
    );

    assign cooler  = (state == COOL);
    assign heater  = (state == HEAT);
    assign busy    = (state != IDLE);
    assign state_o = state;

`ifdef HVAC_FAN_OVERRUN_EN
    localparam int FCW = (FAN_CYCLES < 1) ? 1 : $clog2(FAN_CYCLES + 1);

    logic           running;
    logic           fan_armed;
    logic           fan_done;
    logic [FCW-1:0] fan_count;

    assign running = (state == COOL) || (state == HEAT);

    // The fan timer is held at zero during a run, so overrun restarts on re-entry.
    hvac_timer #(.MAX(FAN_CYCLES), .CW(FCW)) u_fan_timer (
        .clock (clock),
        .reset (reset),
        .clear (running),
        .count (fan_count),
        .done  (fan_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fan_armed <= 1'b0;
        end else if (running) begin
            fan_armed <= 1'b1;
        end else if (fan_done) begin
            fan_armed <= 1'b0;
        end
    end

    assign fan = running || (fan_armed && !fan_done);
`endif

endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed bench for hvac_sequencer: a mode/age model predicts the outputs every
// cycle, and hand-computed literals pin key points of each scenario.
module tb_hvac_sequencer;

    localparam int HYST    = 2;
    localparam int MIN_RUN = 8;
    localparam int MIN_OFF = 4;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        sample_valid = 1'b0;
    logic [31:0] temp_cur = 32'd0;
    logic [31:0] temp_req = 32'd25;
    logic        cooler, heater, busy;
    logic [1:0]  state_o;
`ifdef HVAC_FAN_OVERRUN_EN
    logic        fan;
`endif

    always #5 clock = ~clock;

    hvac_sequencer #(.HYST(HYST), .MIN_RUN(MIN_RUN), .MIN_OFF(MIN_OFF)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .sample_valid (sample_valid),
        .temp_cur     (temp_cur),
        .temp_req     (temp_req),
        .cooler       (cooler),
        .heater       (heater),
        .busy         (busy),
`ifdef HVAC_FAN_OVERRUN_EN
        .fan          (fan),
`endif
        .state_o      (state_o)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 cooling, 2 heating, 3 resting; age: edges spent in mode.
    int          m_mode = 0;
    int          m_age  = 0;
    int          m_next;
    longint      m_diff;
    logic [4:0]  exp_q[$];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_mode = 0;
            m_age  = 0;
        end else begin
            m_next = m_mode;
            m_diff = longint'($signed(temp_cur)) - longint'($signed(temp_req));
            if (m_mode == 0) begin
                if (enable && sample_valid && m_diff > HYST)       m_next = 1;
                else if (enable && sample_valid && m_diff < -HYST) m_next = 2;
            end else if (m_mode == 1) begin
                if (!enable || (sample_valid && m_age >= MIN_RUN && m_diff <= 0)) m_next = 3;
            end else if (m_mode == 2) begin
                if (!enable || (sample_valid && m_age >= MIN_RUN && m_diff >= 0)) m_next = 3;
            end else begin
                if (m_age + 1 >= MIN_OFF) m_next = 0;
            end
            if (m_next != m_mode) m_age = 0;
            else                  m_age++;
            m_mode = m_next;
        end
        exp_q.push_back({2'(m_mode), m_mode == 1, m_mode == 2, m_mode != 0});
    end

    logic [4:0] exp_v;
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q[$];
            exp_q.delete();
            check("model_state", 32'(state_o), 32'(exp_v[4:3]));
            check("model_cooler", 32'(cooler), 32'(exp_v[2]));
            check("model_heater", 32'(heater), 32'(exp_v[1]));
            check("model_busy", 32'(busy), 32'(exp_v[0]));
            check("exclusive", 32'(cooler & heater), 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic strobe(input logic [31:0] cur);
        temp_cur     = cur;
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        #1;
        temp_cur = 32'd35; temp_req = 32'd25; sample_valid = 1'b1;
        reset = 1'b0;
        #1;
        check("rst_cooler", 32'(cooler), 32'd0);
        check("rst_heater", 32'(heater), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick(2);
        check("rst_hold_state", 32'(state_o), 32'd0);
        sample_valid = 1'b0;
        reset = 1'b1;
        tick(1);

        // deadband edges: diff = +2 and -2 must not start anything
        strobe(32'd27);
        check("db_pos_state", 32'(state_o), 32'd0);
        strobe(32'd23);
        check("db_neg_heater", 32'(heater), 32'd0);

        // cooling with an early satisfying sample that must be dropped
        strobe(32'd35);
        check("cool_start", 32'(cooler), 32'd1);
        check("cool_state", 32'(state_o), 32'd1);
        tick(2);
        strobe(32'd24);
        check("cool_early_ignored", 32'(cooler), 32'd1);
        tick(5);
        strobe(32'd24);
        check("cool_exit", 32'(cooler), 32'd0);
        check("cool_rest", 32'(state_o), 32'd3);

        // a heat demand during rest is ignored
        strobe(32'd20);
        check("rest_no_heat", 32'(heater), 32'd0);
        tick(2);
        check("rest_last", 32'(state_o), 32'd3);
        tick(1);
        check("rest_to_idle", 32'(state_o), 32'd0);

        // heating forced off by enable
        strobe(32'd20);
        check("heat_start", 32'(heater), 32'd1);
        check("heat_no_cool", 32'(cooler), 32'd0);
        tick(1);
        enable = 1'b0;
        tick(1);
        check("heat_forced_off", 32'(heater), 32'd0);
        check("heat_forced_rest", 32'(state_o), 32'd3);
        tick(3);
        check("forced_rest_last", 32'(state_o), 32'd3);
        tick(1);
        check("forced_idle", 32'(state_o), 32'd0);
        strobe(32'd20);
        check("disabled_no_start", 32'(state_o), 32'd0);
        tick(2);

        // heating with normal exit at diff = 0
        enable = 1'b1;
        strobe(32'd20);
        tick(8);
        strobe(32'd25);
        check("heat_exit", 32'(state_o), 32'd3);
        tick(4);
        check("heat_exit_idle", 32'(state_o), 32'd0);

        // disable and satisfying sample together
        strobe(32'd35);
        tick(8);
        enable = 1'b0;
        strobe(32'd20);
        check("simul_rest", 32'(state_o), 32'd3);
        enable = 1'b1;
        tick(4);

        // strobe held high: every cycle is a fresh sample
        temp_cur = 32'd35; sample_valid = 1'b1;
        tick(1);
        check("held_cool", 32'(state_o), 32'd1);
        temp_cur = 32'd25;
        tick(8);
        check("held_min_run", 32'(cooler), 32'd1);
        tick(1);
        check("held_exit", 32'(state_o), 32'd3);
        sample_valid = 1'b0;
        tick(4);

        // extreme inputs: the difference must not wrap
        temp_req = 32'h8000_0000;
        strobe(32'h7fff_ffff);
        check("wide_cool", 32'(state_o), 32'd1);
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(4);
        temp_req = 32'h7fff_ffff;
        strobe(32'h8000_0000);
        check("wide_heat", 32'(state_o), 32'd2);
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(4);

        // asynchronous reset in the middle of a heating run
        temp_req = 32'd25;
        strobe(32'd20);
        tick(2);
        #2;
        reset = 1'b0;
        #1;
        check("async_heater", 32'(heater), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick(1);
        check("post_reset_state", 32'(state_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hvac_sequencer.md
Name: hvac_sequencer

Overview:
- Sequences the cooler and heater actuators of the smart-house climate path from a sampled room temperature and the user's requested temperature (`temp_req`, signed 32-bit).
- Adds a hysteresis deadband, a minimum run time, and a mandatory rest interval between actuator runs.
- Guarantees that cooler and heater are never both on, and never switch directly from one to the other.
- Sits between the temperature sensor interface and the house top level, which drives the `cooler` and `heater` outputs.

Parameters:
- HYST, 2: deadband half-width in degrees; demand exists only when |temp_cur - temp_req| > HYST.
- MIN_RUN, 8: minimum clock cycles an actuator stays on once started.
- MIN_OFF, 4: clock cycles both actuators are held off after any run ends.
- FAN_CYCLES, 6: fan overrun length in cycles (used only with the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  climate control enabled; low forces actuators off.
- sample_valid  in  1  single-cycle strobe; temp_cur is valid this cycle.
- temp_cur  in  32  signed measured temperature.
- temp_req  in  32  signed requested temperature.
- cooler  out  1  cooler drive.
- heater  out  1  heater drive.
- busy  out  1  high whenever state != IDLE.
- state_o  out  2  current state encoding, for debug.

Behaviour:
- Reset (reset=0), asynchronous:
  - state=IDLE, timer=0.
  - cooler=0, heater=0, busy=0, fan=0.
  - All outputs go low with no clock edge required.
- Arithmetic:
  - diff = temp_cur - temp_req, computed at 33-bit signed; no overflow for any 32-bit inputs.
  - Comparisons against +HYST and -HYST are signed.
  - diff is evaluated only in a cycle where sample_valid=1.
- States: IDLE=0, COOL=1, HEAT=2, REST=3. Outputs are Moore, decoded from the state register: cooler=(state==COOL), heater=(state==HEAT).
- IDLE:
  - If enable & sample_valid & diff>HYST: go to COOL.
  - Else if enable & sample_valid & diff<-HYST: go to HEAT.
  - Otherwise stay in IDLE.
  - The actuator rises on the edge that samples the strobe, so it is visible one cycle after the strobe cycle.
- COOL/HEAT:
  - The timer clears on entry and then increments each cycle, saturating at MIN_RUN.
  - Normal exit to REST: sample_valid & timer>=MIN_RUN & (COOL: diff<=0; HEAT: diff>=0).
  - A satisfying sample that arrives before the timer reaches MIN_RUN is discarded; a later sample is required to exit.
- Forced exit: enable=0 in COOL or HEAT moves to REST on the next edge, regardless of the timer.
- REST:
  - Both actuators are off; the timer clears on entry.
  - After MIN_OFF cycles in REST, go to IDLE.
  - sample_valid and enable are ignored in REST.
- Invariants:
  - COOL->HEAT and HEAT->COOL transitions do not exist; every path passes through REST.
  - cooler & heater is never 1.
- Simultaneous events: enable=0 and a satisfying sample in the same cycle both lead to REST, with identical result.
- sample_valid held high for several cycles is treated as a fresh sample each cycle.

Optional Feature:
- Macro: HVAC_FAN_OVERRUN_EN.
- When defined:
  - Adds output `fan` (1 bit).
  - fan=1 while in COOL or HEAT.
  - fan stays 1 for FAN_CYCLES cycles after leaving COOL or HEAT, using its own counter that runs independently of the REST timer.
  - Re-entering COOL or HEAT restarts the overrun.
  - Reset clears fan.
- When undefined: no fan port and no overrun logic; all other behaviour is unchanged.

Decomposition:
- Shared package `smart_house_pkg`:
  - State encoding constants IDLE, COOL, HEAT, REST.
  - Temperature width constant TEMP_W=32.
- Sub-module `hvac_timer`:
  - Clearable saturating up-counter with parameter MAX.
  - Outputs the count and `done`.
  - Instantiated once for the run/rest timer and once for the fan overrun.

Test Plan (HYST=2, MIN_RUN=8, MIN_OFF=4):
- reset=0 with temp_cur=35, temp_req=25, sample_valid=1 -> cooler=heater=busy=0. After release, a strobe -> cooler=1 one cycle after the strobe, state_o=1.
- temp_cur=27, temp_req=25 (diff=2) and temp_cur=23 (diff=-2), strobed -> stays IDLE, both actuators 0.
- Cooling started, temp_cur=24 strobed at run cycle 3 -> ignored, cooler stays 1. Strobe again at cycle 9 -> cooler=0, REST for 4 cycles, then IDLE.
- temp_cur=20, temp_req=25 strobed during REST -> no heater. Strobe in IDLE -> heater=1 next cycle; cooler never asserted with heater.
- enable=0 at run cycle 2 of HEAT -> heater=0 next cycle, REST 4 cycles, IDLE. A strobe in IDLE with enable=0 -> no start.
- reset asserted mid-HEAT between clock edges -> heater=0 immediately without a clock edge. After release, state_o=0.
